dmem_byte_master: RTL and testbench
===================================

Name: dmem_byte_master

Overview:
- Initiator for the byte-wide debug port of the data memory unit. Drives en/we/addr/din and captures dout.
- Converts a host command (base address, byte count, direction) into a burst of single-byte memory accesses.
- Bridges the burst to valid/ready byte streams. Used by the host-side loader and dump logic to preload and read back data memory.

Parameters:
ADDR_WIDTH, 64, byte address width of the memory port
LEN_WIDTH, 16, width of the byte-count field
RD_LATENCY, 2, cycles from an accepted read (mem_en=1, mem_we=0) to valid mem_dout
FIFO_DEPTH, 4, read-return FIFO entries; must be >= RD_LATENCY+1, power of two

Ports:
clk  in  1  single clock; memory port runs on this clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  first byte address
cmd_len  in  LEN_WIDTH  number of bytes; 0 is legal
wr_valid  in  1  write byte offered
wr_ready  out  1  write byte accepted
wr_data  in  8  write byte
rd_valid  out  1  read byte available
rd_ready  in  1  consumer accepts read byte
rd_data  out  8  read byte
rd_last  out  1  qualifies the final byte of a read burst
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
mem_en  out  1  memory port enable
mem_we  out  1  memory port write enable
mem_addr  out  ADDR_WIDTH  memory byte address
mem_din  out  8  memory write byte
mem_dout  in  8  memory read byte, valid RD_LATENCY cycles after issue

Behaviour:
- Reset: all outputs 0. State IDLE; counters 0; FIFO empty; in-flight read tracking cleared.
- Reset mid-burst aborts the burst. No done pulse is generated. Returns arriving after reset are discarded.
- States are IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1; busy=0.
  - On handshake, latch addr and len (remaining count).
  - len=0: no memory access; done=1 on the next cycle; stay IDLE. cmd_ready=0 in that cycle.
  - Otherwise go to WRITE or READ; busy=1 from the cycle after acceptance.
- WRITE:
  - wr_ready=1.
  - Each wr_valid&wr_ready cycle drives, combinationally in that same cycle, mem_en=1, mem_we=1, mem_addr=current addr, mem_din=wr_data.
  - Each such cycle increments addr (mod 2^ADDR_WIDTH) and decrements remaining.
  - When the last byte is accepted, go to IDLE with done=1 the following cycle.
  - With no wr_valid: mem_en=0, no progress.
- READ:
  - Issue a read (mem_en=1, mem_we=0, mem_addr=addr) when remaining!=0 and FIFO occupancy + in-flight < FIFO_DEPTH.
  - This credit rule guarantees no return is ever dropped.
  - In-flight is tracked by a RD_LATENCY-deep valid shift register.
  - The return is written into the FIFO in the cycle it is valid.
  - After the last issue, go to DRAIN.
- DRAIN:
  - No issues.
  - When in-flight=0, FIFO empty and the last byte has been handed over, go to IDLE with done=1 the next cycle.
- Read output:
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - rd_last=1 when the head is byte number len-1 of the burst (delivered-byte counter).
  - Head pops on rd_valid&rd_ready.
  - The FIFO supports a same-cycle push and pop when full-minus-one or empty; bypass is not required (minimum latency RD_LATENCY+1 cycles from issue to rd_valid).
- Throughput:
  - Writes: 1 byte/cycle with continuous wr_valid.
  - Reads: 1 byte/cycle with rd_ready held high.
- Address: wraps from 2^ADDR_WIDTH-1 to 0 without error.
- Command during a burst: cmd_ready=0; not accepted.
- A wr_valid held in READ/IDLE is ignored (wr_ready=0).

Decomposition:
- Shared package: state encoding (IDLE/WRITE/READ/DRAIN) and a default RD_LATENCY constant matching the data memory unit.
- One sub-module: byte_fifo (parameter DEPTH; push/pop/full/empty/count), used for read returns.

Test Plan:
- Write burst: addr=0x100, len=4, bytes AA,BB,CC,DD back-to-back -> mem_we pulses at 0x100..0x103 on 4 consecutive cycles; done 1 cycle after the last; busy drops with it.
- Read burst, rd_ready=1: memory model preloaded 0x100..0x103 = AA..DD, latency 2 -> rd_data AA,BB,CC,DD on consecutive cycles; rd_last only on DD; done after DD.
- Read with backpressure: len=16, rd_ready toggling 1 cycle on / 3 off -> all 16 bytes delivered in order; never more than FIFO_DEPTH outstanding; no loss.
- len=0 command, read and write -> no mem_en; done one cycle after acceptance; cmd_ready low that cycle.
- Wrap: addr=0xFFFF_FFFF_FFFF_FFFE, len=4 write -> addresses ...FE, ...FF, 0x0, 0x1.
- Reset during read with 2 in flight -> all outputs 0 next cycle; stale returns not seen on rd_valid; next command executes correctly.

Source files
------------

// File: rtl/dmem_byte_master_pkg.sv
// Shared definitions for the data-memory byte-port initiator.
package dmem_byte_master_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Read latency of the data memory unit's debug port.
  localparam int DEFAULT_RD_LATENCY = 2;

endpackage

// File: rtl/dmem_byte_master_byte_fifo.sv
// Small byte FIFO that holds read returns until the consumer takes them.
// Head is presented combinationally so rd_data tracks the head entry.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

  // Storage array, no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/dmem_byte_master.sv
// Byte-wide initiator for the data memory debug port: turns a host command
// into a burst of single-byte accesses bridged to valid/ready byte streams.
module dmem_byte_master
  import dmem_byte_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  delivered_reg, delivered_next;
  logic                  done_reg, done_next;
  logic                  zero_done_reg, zero_done_next;
  logic [RD_LATENCY-1:0] inflight_reg, inflight_next;

  logic                  wr_fire;
  logic                  rd_issue;
  logic                  rd_pop;
  logic [OUT_W-1:0]      outstanding;
  logic [7:0]            fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  // Read returns; a return lands in the FIFO exactly when its tracking bit exits the shift register.
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (inflight_reg[RD_LATENCY-1]),
    .push_data (mem_dout),
    .pop       (rd_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // In-flight tracking: one bit per cycle of memory latency.
  assign inflight_next[0] = rd_issue;
  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_inflight
    assign inflight_next[gi] = inflight_reg[gi-1];
  end

  // Credit count: bytes buffered plus bytes still in the memory pipeline.
  always_comb begin
    outstanding = OUT_W'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) begin
      outstanding = outstanding + OUT_W'(inflight_reg[i]);
    end
  end

  assign rd_valid = !rst && !fifo_empty;
  assign rd_data  = rd_valid ? fifo_head : 8'h00;
  assign rd_last  = rd_valid && (delivered_reg == len_reg - LEN_WIDTH'(1));
  assign rd_pop   = rd_valid && rd_ready;
  assign busy     = !rst && (state_reg != ST_IDLE);
  assign done     = !rst && done_reg;
  assign mem_en   = wr_fire || rd_issue;
  assign mem_we   = wr_fire;
  assign mem_addr = mem_en ? addr_reg : '0;
  assign mem_din  = wr_fire ? wr_data : 8'h00;

  // State and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      len_reg       <= '0;
      delivered_reg <= '0;
      done_reg      <= 1'b0;
      zero_done_reg <= 1'b0;
      inflight_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      len_reg       <= len_next;
      delivered_reg <= delivered_next;
      done_reg      <= done_next;
      zero_done_reg <= zero_done_next;
      inflight_reg  <= inflight_next;
    end
  end

  // Next-state and handshake logic; everything is held quiet while reset is asserted.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    len_next       = len_reg;
    delivered_next = rd_pop ? delivered_reg + LEN_WIDTH'(1) : delivered_reg;
    done_next      = 1'b0;
    zero_done_next = 1'b0;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    wr_fire        = 1'b0;
    rd_issue       = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE: begin
          // The done cycle of a zero-length command refuses a new command.
          cmd_ready = !zero_done_reg;
          if (cmd_valid && !zero_done_reg) begin
            addr_next      = cmd_addr;
            remaining_next = cmd_len;
            len_next       = cmd_len;
            delivered_next = '0;
            if (cmd_len == '0) begin
              done_next      = 1'b1;
              zero_done_next = 1'b1;
            end else begin
              state_next = cmd_write ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          wr_ready = 1'b1;
          wr_fire  = wr_valid;
          if (wr_valid) begin
            addr_next      = addr_reg + ADDR_WIDTH'(1);
            remaining_next = remaining_reg - LEN_WIDTH'(1);
            if (remaining_reg == LEN_WIDTH'(1)) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
        end
        ST_READ: begin
          // Only issue when the FIFO is guaranteed room for the return.
          rd_issue = (remaining_reg != '0) && (outstanding < OUT_W'(FIFO_DEPTH)) && !fifo_full;
          if (rd_issue) begin
            addr_next      = addr_reg + ADDR_WIDTH'(1);
            remaining_next = remaining_reg - LEN_WIDTH'(1);
            if (remaining_reg == LEN_WIDTH'(1)) begin
              state_next = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The final byte leaving the FIFO implies nothing remains in flight.
          if (rd_pop && rd_last) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_master.sv
// Directed bench for dmem_byte_master: table of bursts plus hand-written corner sequences.
module tb_dmem_byte_master;

  localparam int AW    = 64;
  localparam int LW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [7:0]    wr_data = 8'h00;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;

  int vec_count = 0;
  int err_count = 0;

  dmem_byte_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: 1 KiB indexed by the low address bits, two-cycle read latency.
  logic [7:0] mem_model [1024];
  logic [7:0] rd_pipe;
  bit         preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= 8'(i) ^ 8'h5A;
      preloaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem_model[mem_addr[9:0]] <= mem_din;
    end
    rd_pipe  <= (mem_en && !mem_we) ? mem_model[mem_addr[9:0]] : 8'hEE;
    mem_dout <= rd_pipe;
  end

  // Bench's own expectation of memory contents.
  logic [7:0] exp_mem [1024];

  typedef struct {
    string         name;
    bit            write;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [7:0]    seed;
    logic [7:0]    step;
    bit            bp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_last"}, rd_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
  endtask

  // Write burst; starts and ends aligned to a falling edge.
  task automatic do_write(input string name, input logic [AW-1:0] a, input logic [LW-1:0] n,
                          input logic [7:0] seed, input logic [7:0] step);
    logic [7:0] d;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = n;
    #1;
    check({name, "_cmd_ready"}, cmd_ready, 1);
    check({name, "_busy_idle"}, busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      d = 8'(int'(seed) + i * int'(step));
      wr_valid = 1'b1; wr_data = d;
      #1;
      check({name, "_wr_ready"}, wr_ready, 1);
      check({name, "_mem_en"}, mem_en, 1);
      check({name, "_mem_we"}, mem_we, 1);
      check({name, "_mem_addr"}, mem_addr, a + AW'(i));
      check({name, "_mem_din"}, mem_din, d);
      check({name, "_busy"}, busy, 1);
      check({name, "_done_early"}, done, 0);
      exp_mem[10'(a + AW'(i))] = d;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    check({name, "_done"}, done, 1);
    check({name, "_busy_end"}, busy, 0);
    check({name, "_mem_en_end"}, mem_en, 0);
    check({name, "_cmd_ready_done"}, cmd_ready, (n != 0));
    @(negedge clk);
    #1;
    check({name, "_done_pulse"}, done, 0);
    @(negedge clk);
    $display("[%0t] %s: write addr=%h len=%0d", $time, name, a, n);
  endtask

  // Read burst with optional 1-on/3-off backpressure.
  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [LW-1:0] n, input bit bp);
    int  issued = 0, got = 0, first_pop = -1, last_pop = -1, done_c = -1;
    bit  done_seen = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = n;
    #1;
    check({name, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      rd_ready = bp ? (c % 4 == 0) : 1'b1;
      #1;
      if (done) begin
        done_seen = 1'b1;
        done_c = c;
        check({name, "_busy_end"}, busy, 0);
        check({name, "_mem_en_end"}, mem_en, 0);
        check({name, "_cmd_ready_done"}, cmd_ready, (n != 0));
      end else begin
        check({name, "_busy"}, busy, 1);
        if (mem_en) begin
          check({name, "_mem_we"}, mem_we, 0);
          check({name, "_mem_addr"}, mem_addr, a + AW'(issued));
          issued++;
        end
        if (rd_valid && rd_ready) begin
          if (first_pop < 0) first_pop = c;
          check({name, "_rd_data"}, rd_data, exp_mem[10'(a + AW'(got))]);
          check({name, "_rd_last"}, rd_last, (got == int'(n) - 1));
          if (!bp) check({name, "_consecutive"}, c, first_pop + got);
          got++;
          last_pop = c;
        end
        check({name, "_outstanding_over"}, (issued - got) > DEPTH, 0);
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check({name, "_done_seen"}, done_seen, 1);
    check({name, "_issued"}, issued, n);
    check({name, "_delivered"}, got, n);
    check({name, "_done_cycle"}, done_c, (n == 0) ? 0 : last_pop + 1);
    if (!bp && n != 0) check({name, "_first_latency"}, first_pop, 3);
    #1;
    check({name, "_done_pulse"}, done, 0);
    @(negedge clk);
    $display("[%0t] %s: read addr=%h len=%0d delivered=%0d", $time, name, a, n, got);
  endtask

  initial begin
    vecs[0] = '{"wr4",    1'b1, 64'h100,                 16'd4,  8'hAA, 8'h11, 1'b0};
    vecs[1] = '{"rd4",    1'b0, 64'h100,                 16'd4,  8'h00, 8'h00, 1'b0};
    vecs[2] = '{"rd16bp", 1'b0, 64'h200,                 16'd16, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{"wr0",    1'b1, 64'h180,                 16'd0,  8'h00, 8'h00, 1'b0};
    vecs[4] = '{"rd0",    1'b0, 64'h180,                 16'd0,  8'h00, 8'h00, 1'b0};
    vecs[5] = '{"wrwrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 16'd4,  8'h10, 8'h01, 1'b0};
    vecs[6] = '{"rdwrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 16'd4,  8'h00, 8'h00, 1'b0};
    vecs[7] = '{"rd3bp",  1'b0, 64'h203,                 16'd3,  8'h00, 8'h00, 1'b1};

    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'(i) ^ 8'h5A;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].write) do_write(vecs[v].name, vecs[v].addr, vecs[v].len, vecs[v].seed, vecs[v].step);
      else               do_read(vecs[v].name, vecs[v].addr, vecs[v].len, vecs[v].bp);
    end

    // Command offered mid-burst is refused and leaves no trace.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 64'h300; cmd_len = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h0; cmd_len = 16'd5;
    #1;
    check("midcmd_cmd_ready", cmd_ready, 0);
    check("midcmd_mem_en", mem_en, 0);
    check("midcmd_busy", busy, 1);
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h11;
    #1;
    check("midcmd_addr0", mem_addr, 64'h300);
    exp_mem[10'h300] = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    #1;
    check("midcmd_addr1", mem_addr, 64'h301);
    exp_mem[10'h301] = 8'h22;
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("midcmd_done", done, 1);
    @(negedge clk);
    #1;
    check("midcmd_idle_busy", busy, 0);
    check("midcmd_idle_mem_en", mem_en, 0);
    @(negedge clk);
    $display("[%0t] midcmd: refused command during write burst", $time);

    // wr_valid while idle is ignored.
    wr_valid = 1'b1; wr_data = 8'h77;
    #1;
    check("idle_wr_ready", wr_ready, 0);
    check("idle_wr_mem_en", mem_en, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    $display("[%0t] idlewr: wr_valid ignored in idle", $time);

    // Reset with two reads in flight.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h200; cmd_len = 16'd8;
    @(negedge clk);
    cmd_valid = 1'b0; rd_ready = 1'b0;
    #1;
    check("rst_issue0", mem_en, 1);
    @(negedge clk);
    #1;
    check("rst_issue1", mem_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("postrst_rd_valid", rd_valid, 0);
      check("postrst_done", done, 0);
      @(negedge clk);
    end
    $display("[%0t] midrst: reset aborted read with returns in flight", $time);
    do_read("rd_after_rst", 64'h300, 16'd2, 1'b0);
    do_read("rd4_again", 64'h100, 16'd4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d miscompares so far", err_count);
    $fatal(1, "timeout");
  end

endmodule
